brew_sequencer: RTL and testbench

//  Sequences one drink cycle: heat, coffee, hot water, milk. Input is the 3-bit drink code from the switch decoder.

---
 rtl/brew_sequencer.sv | 149 ++++++++++++++
 tb/tb_brew_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/brew_sequencer.sv
// Drink-cycle sequencer: heat, coffee, hot water, milk from a fixed recipe table.
// Handles cancel, water-loss and heat-timeout aborts with a sticky error code.
module brew_sequencer #(
  parameter int TICK_DIV     = 50_000_000,
  parameter int HEAT_TIMEOUT = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] c_type,
  input  logic       start,
  input  logic       cancel,
  input  logic       water_ok,
  input  logic       temp_ok,
  output logic       heater,
  output logic       pump_coffee,
  output logic       valve_water,
  output logic       pump_milk,
  output logic       busy,
  output logic       done,
  output logic [1:0] err_code,
  output logic [2:0] phase,
  output logic [7:0] ticks_left
);

  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEAT   = 3'd1,
    S_COFFEE = 3'd2,
    S_WATER  = 3'd3,
    S_MILK   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] pre;
  logic [7:0]    cnt, cnt_n;
  logic [2:0]    drink, drink_n;
  logic [1:0]    err, err_n;
  logic [7:0]    t_cof, t_wat, t_mlk;
  logic          tick, sel_ok, last;

  assign tick   = (pre == PW'(TICK_DIV - 1));
  assign last   = tick && (cnt == 8'd1);
  assign sel_ok = (c_type >= 3'd1) && (c_type <= 3'd4);

  always_comb begin
    t_cof = 8'd0;
    t_wat = 8'd0;
    t_mlk = 8'd0;
    unique case (drink)
      3'd1: t_cof = 8'd3;
      3'd2: begin t_cof = 8'd3; t_wat = 8'd5; end
      3'd3: begin t_cof = 8'd3; t_mlk = 8'd4; end
      3'd4: begin t_cof = 8'd2; t_mlk = 8'd6; end
      default: ;
    endcase
  end

  // cnt holds the heat-timeout budget in HEAT and recipe ticks elsewhere
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    drink_n = drink;
    err_n   = err;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (!water_ok) begin
            err_n = 2'b10;
          end else if (!sel_ok) begin
            err_n = 2'b01;
          end else begin
            drink_n = c_type;
            err_n   = 2'b00;
            state_n = S_HEAT;
            cnt_n   = 8'(HEAT_TIMEOUT);
          end
        end
      end
      S_HEAT: begin
        if (cancel) begin
          state_n = S_IDLE;
        end else if (last) begin
          state_n = S_IDLE;
          err_n   = 2'b11;
        end else if (temp_ok) begin
          state_n = S_COFFEE;
          cnt_n   = t_cof;
        end else if (tick) begin
          cnt_n = cnt - 8'd1;
        end
      end
      S_COFFEE, S_WATER, S_MILK: begin
        if (cancel) begin
          state_n = S_IDLE;
        end else if (!water_ok) begin
          state_n = S_IDLE;
          err_n   = 2'b10;
        end else if (last) begin
          if (state == S_COFFEE && t_wat != 8'd0) begin
            state_n = S_WATER;
            cnt_n   = t_wat;
          end else if (state != S_MILK && t_mlk != 8'd0) begin
            state_n = S_MILK;
            cnt_n   = t_mlk;
          end else begin
            state_n = S_DONE;
          end
        end else if (tick) begin
          cnt_n = cnt - 8'd1;
        end
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (state_n == S_IDLE || state_n == S_DONE) cnt_n = 8'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 8'd0;
      drink <= 3'd0;
      err   <= 2'b00;
      pre   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      drink <= drink_n;
      err   <= err_n;
      if (state_n != state || tick) pre <= '0;
      else pre <= pre + 1'b1;
    end
  end

  assign heater      = (state == S_HEAT) || (state == S_COFFEE) ||
                       (state == S_WATER);
  assign pump_coffee = (state == S_COFFEE);
  assign valve_water = (state == S_WATER);
  assign pump_milk   = (state == S_MILK);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign err_code    = err;
  assign phase       = state;
  assign ticks_left  = cnt;

endmodule

// File: tb/tb_brew_sequencer.sv
// Bench for brew_sequencer: cycle-count reference model plus directed scenarios.
// Phase durations are tracked in clock cycles and ticks derived by division.
module tb_brew_sequencer;

  localparam int TD = 4;
  localparam int HT = 8;

  logic       clk, rst, start, cancel, water_ok, temp_ok;
  logic [2:0] c_type;
  logic       heater, pump_coffee, valve_water, pump_milk, busy, done;
  logic [1:0] err_code;
  logic [2:0] phase;
  logic [7:0] ticks_left;

  int vectors = 0;
  int miscompares = 0;

  brew_sequencer #(.TICK_DIV(TD), .HEAT_TIMEOUT(HT)) dut (
    .clk(clk), .rst(rst), .c_type(c_type), .start(start),
    .cancel(cancel), .water_ok(water_ok), .temp_ok(temp_ok),
    .heater(heater), .pump_coffee(pump_coffee),
    .valve_water(valve_water), .pump_milk(pump_milk),
    .busy(busy), .done(done), .err_code(err_code),
    .phase(phase), .ticks_left(ticks_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int rec [1:4][0:2] = '{'{3, 0, 0}, '{3, 5, 0}, '{3, 0, 4}, '{2, 0, 6}};

  int m_ph = 0, m_rem = 0, m_heat = 0, m_drink = 1, m_err = 0;
  bit armed = 0;

  function automatic int next_ph(int cur, int d);
    for (int p = cur + 1; p <= 4; p++)
      if (rec[d][p-2] != 0) return p;
    return 5;
  endfunction

  function automatic int load(int p, int d);
    if (p >= 2 && p <= 4) return rec[d][p-2] * TD;
    return 0;
  endfunction

  always @(posedge clk) begin
    armed <= 1'b1;
    if (rst) begin
      m_ph <= 0; m_rem <= 0; m_heat <= 0; m_err <= 0;
    end else begin
      case (m_ph)
        0: if (start) begin
          if (!water_ok) m_err <= 2;
          else if (c_type < 1 || c_type > 4) m_err <= 1;
          else begin
            m_drink <= int'(c_type); m_err <= 0;
            m_ph <= 1; m_heat <= 0;
          end
        end
        1: begin
          if (cancel) m_ph <= 0;
          else if (m_heat + 1 == HT * TD) begin
            m_ph <= 0; m_err <= 3;
          end else if (temp_ok) begin
            m_ph <= 2; m_rem <= load(2, m_drink);
          end else m_heat <= m_heat + 1;
        end
        2, 3, 4: begin
          if (cancel) m_ph <= 0;
          else if (!water_ok) begin
            m_ph <= 0; m_err <= 2;
          end else if (m_rem == 1) begin
            m_ph  <= next_ph(m_ph, m_drink);
            m_rem <= load(next_ph(m_ph, m_drink), m_drink);
          end else m_rem <= m_rem - 1;
        end
        default: m_ph <= 0;
      endcase
    end
  end

  logic [10:0] act, exp_v;
  int exp_tl;
  always @(negedge clk) begin
    if (armed) begin
      act = {heater, pump_coffee, valve_water, pump_milk,
             busy, done, err_code, phase};
      exp_v = {m_ph >= 1 && m_ph <= 3, m_ph == 2, m_ph == 3,
               m_ph == 4, m_ph != 0, m_ph == 5,
               2'(m_err), 3'(m_ph)};
      vectors++;
      if (act !== exp_v) begin
        miscompares++;
        $display("FAIL outputs t=%0t actual=%b required=%b",
                 $time, act, exp_v);
      end
      if (m_ph != 1) begin
        exp_tl = (m_ph >= 2 && m_ph <= 4) ? (m_rem + TD - 1) / TD : 0;
        vectors++;
        if (ticks_left !== 8'(exp_tl)) begin
          miscompares++;
          $display("FAIL ticks_left t=%0t actual=%0d required=%0d",
                   $time, ticks_left, exp_tl);
        end
      end
    end
  end

  int hist [0:7];
  int dn = 0, pc = 0, vw = 0, pm = 0;
  always @(negedge clk) begin
    hist[phase] = hist[phase] + 1;
    if (done) dn++;
    if (pump_coffee) pc++;
    if (valve_water) vw++;
    if (pump_milk) pm++;
  end

  task automatic clr;
    for (int i = 0; i < 8; i++) hist[i] = 0;
    dn = 0; pc = 0; vw = 0; pm = 0;
  endtask

  task automatic chk(input string nm, input int a, input int e);
    vectors++;
    if (a != e) begin
      miscompares++;
      $display("FAIL %s actual=%0d required=%0d", nm, a, e);
    end
  endtask

  task automatic pulse_start;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_phase(input int p, input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (phase != 3'(p) && n < 200);
    chk({nm, "_reached"}, int'(phase == 3'(p)), 1);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (phase != 3'd0 && n < 200);
    #1 chk({nm, "_idle"}, int'(phase), 0);
  endtask

  task automatic pulse_cancel;
    #1 cancel = 1'b1;
    @(posedge clk); #1 cancel = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cancel = 1'b0;
    water_ok = 1'b1; temp_ok = 1'b0; c_type = 3'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_phase", int'(phase), 0);
    chk("rst_err", int'(err_code), 0);
    chk("rst_outs", int'({heater, pump_coffee, valve_water,
                          pump_milk, busy, done}), 0);

    // americano with late temp_ok
    clr(); c_type = 3'd2;
    pulse_start();
    @(posedge clk); @(posedge clk); #1 temp_ok = 1'b1;
    wait_idle("amer");
    chk("amer_heat", hist[1], 3);
    chk("amer_coffee", pc, 12);
    chk("amer_water", vw, 20);
    chk("amer_milk", pm, 0);
    chk("amer_done", dn, 1);

    // invalid then valid selection; c_type change after start ignored
    clr(); c_type = 3'd0;
    pulse_start();
    @(negedge clk);
    chk("bad_phase", int'(phase), 0);
    chk("bad_err", int'(err_code), 1);
    c_type = 3'd1;
    pulse_start();
    c_type = 3'd2;
    @(negedge clk);
    chk("esp_phase", int'(phase), 1);
    chk("esp_err", int'(err_code), 0);
    wait_idle("esp");
    chk("esp_coffee", pc, 12);
    chk("esp_water", vw, 0);
    chk("esp_done", dn, 1);

    // cappuccino cancelled on 5th MILK cycle
    clr(); c_type = 3'd3;
    pulse_start();
    wait_phase(4, "cap");
    repeat (4) @(posedge clk);
    pulse_cancel();
    @(negedge clk);
    chk("cap_phase", int'(phase), 0);
    chk("cap_acts", int'({heater, pump_coffee, valve_water, pump_milk}), 0);
    chk("cap_milk", pm, 5);
    chk("cap_done", dn, 0);
    chk("cap_err", int'(err_code), 0);

    // latte, heat timeout with ignored extra starts
    clr(); c_type = 3'd4; temp_ok = 1'b0;
    pulse_start();
    repeat (5) @(posedge clk);
    c_type = 3'd1;
    pulse_start();
    repeat (10) @(posedge clk);
    pulse_start();
    wait_idle("tmo");
    chk("tmo_heat", hist[1], 32);
    chk("tmo_err", int'(err_code), 3);
    chk("tmo_coffee", pc, 0);

    // full latte
    clr(); c_type = 3'd4; temp_ok = 1'b1;
    pulse_start();
    wait_idle("lat");
    chk("lat_heat", hist[1], 1);
    chk("lat_coffee", pc, 8);
    chk("lat_milk", pm, 24);
    chk("lat_done", dn, 1);
    chk("lat_err", int'(err_code), 0);

    // cancel coinciding with final tick of COFFEE
    clr(); c_type = 3'd1;
    pulse_start();
    wait_phase(2, "fin");
    repeat (11) @(posedge clk);
    pulse_cancel();
    @(negedge clk);
    chk("fin_phase", int'(phase), 0);
    chk("fin_coffee", pc, 12);
    chk("fin_done", dn, 0);

    // water loss mid-COFFEE, then start without water
    clr(); c_type = 3'd1;
    pulse_start();
    wait_phase(2, "wl");
    repeat (5) @(posedge clk);
    #1 water_ok = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("wl_phase", int'(phase), 0);
    chk("wl_err", int'(err_code), 2);
    chk("wl_done", dn, 0);
    pulse_start();
    @(negedge clk);
    chk("nw_phase", int'(phase), 0);
    chk("nw_err", int'(err_code), 2);

    // cancel in IDLE has no effect
    water_ok = 1'b1;
    @(posedge clk);
    pulse_cancel();
    @(negedge clk);
    chk("idle_cancel_err", int'(err_code), 2);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
